// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (master) and mem_responder (slave).
// Carries a single-outstanding request channel and a held response channel.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with byte/halfword/word writes and fixed latency.
// Define MEM_RESPONDER_ERR_EN to reject misaligned and out-of-range accesses with rsp_err.
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [1:0]  we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;

    logic [AW-1:0] idx;
    logic          access_fire;
    logic          err_next;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   rdata_w;

    assign idx         = addr_reg[2 +: AW];
    assign access_fire = (state_reg == ACCESS) && (cnt_reg == 4'd0);

`ifdef MEM_RESPONDER_ERR_EN
    always_comb begin
        err_next = 1'b0;
        if (we_reg == 2'b10 && addr_reg[0])
            err_next = 1'b1;
        if (we_reg == 2'b11 && addr_reg[1:0] != 2'b00)
            err_next = 1'b1;
        if (addr_reg[31:2] >= 30'(DEPTH))
            err_next = 1'b1;
    end
`else
    assign err_next = 1'b0;
`endif

    // Upper address bits only matter for the range check in the error build.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_reg[31:AW+2];

    // Narrow writes replicate their data so each lane can pick its own slice.
    always_comb begin
        be = 4'b0000;
        wd = wdata_reg;
        case (we_reg)
            2'b01: begin
                be = 4'b0001 << addr_reg[1:0];
                wd = {4{wdata_reg[7:0]}};
            end
            2'b10: begin
                be = addr_reg[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_reg[15:0]}};
            end
            2'b11: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (err_next)
            be = 4'b0000;
    end

    // One byte-wide RAM per lane keeps byte enables trivial to infer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (!reset && access_fire && be[gi])
                    mem_lane[idx] <= wd[8*gi +: 8];
            end

            always_ff @(posedge clk) begin
                if (reset)
                    rd_reg <= 8'h00;
                else if (access_fire && we_reg == 2'b00)
                    rd_reg <= err_next ? 8'h00 : mem_lane[idx];
            end

            assign rdata_w[8*gi +: 8] = rd_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        we_reg        <= bus.req_we;
                        addr_reg      <= bus.req_addr;
                        wdata_reg     <= bus.req_wdata;
                        cnt_reg       <= 4'(LATENCY);
                        req_ready_reg <= 1'b0;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= err_next;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    // req_ready comes back only after the response edge, never on it.
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rdata_w;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: DUT A (DEPTH=1024, LATENCY=2), DUT B (DEPTH=4, LATENCY=0).
// Expectations come from a word-level reference model; honours MEM_RESPONDER_ERR_EN when defined.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        v;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rr;

    mem_responder_if ifa();
    mem_responder_if ifb();

    assign ifa.req_valid = v & ~sel;
    assign ifb.req_valid = v & sel;
    assign ifa.req_we    = we;
    assign ifb.req_we    = we;
    assign ifa.req_addr  = addr;
    assign ifb.req_addr  = addr;
    assign ifa.req_wdata = wdata;
    assign ifb.req_wdata = wdata;
    assign ifa.rsp_ready = rr & ~sel;
    assign ifb.rsp_ready = rr & sel;

    mem_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mem_responder #(.DEPTH(4),    .LATENCY(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    assign o_req_ready = sel ? ifb.req_ready : ifa.req_ready;
    assign o_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign o_rsp_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign o_rsp_err   = sel ? ifb.rsp_err   : ifa.rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] last_rd [2];
    int errors = 0;
    int checks = 0;

    function automatic int dep();
        return sel ? 4 : 1024;
    endfunction

    function automatic int lat();
        return sel ? 0 : 2;
    endfunction

    function automatic logic exp_err(input logic [1:0] w, input logic [31:0] a);
`ifdef MEM_RESPONDER_ERR_EN
        if (w == 2'b10 && a[0]) return 1'b1;
        if (w == 2'b11 && a[1:0] != 2'b00) return 1'b1;
        if (int'(a[31:2]) >= dep()) return 1'b1;
        return 1'b0;
`else
        return (w == 2'b00) && (a == 32'hFFFF_FFFF) && (dep() < 0);
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] w,
                                          input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (w)
            2'b01: r[8*a[1:0] +: 8] = d[7:0];
            2'b10: r[16*a[1] +: 16] = d[15:0];
            2'b11: r = d;
            default: r = old;
        endcase
        return r;
    endfunction

    task automatic do_access(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                             input int hold, input string nm);
        int n;
        int k;
        exp_t e;
        exp_t got;
        @(negedge clk);
        v = 1'b1; we = w; addr = a; wdata = d;
        n = 0;
        while (o_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b required 1", nm, o_req_ready);
            v = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble inputs after acceptance: the captured request must be used.
        v = 1'b0; we = 2'($urandom); addr = $urandom; wdata = $urandom;

        e.err = exp_err(w, a);
        k = (sel ? 65536 : 0) + int'((a >> 2) % dep());
        if (w == 2'b00) begin
            e.rdata = e.err ? 32'h0 : model[k];
            last_rd[sel] = e.rdata;
        end else begin
            e.rdata = last_rd[sel];
            if (!e.err)
                model[k] = merge(model.exists(k) ? model[k] : 32'h0, w, a, d);
        end
        sb.push_back(e);

        n = 0;
        while (o_rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != lat() + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required %0d", nm, n, lat() + 1);
            if (o_rsp_valid !== 1'b1) begin
                void'(sb.pop_front());
                return;
            end
        end
        got = sb.pop_front();
        checks++;
        if (o_rsp_rdata !== got.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %08h required %08h", nm, o_rsp_rdata, got.rdata);
        end
        checks++;
        if (o_rsp_err !== got.err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", nm, o_rsp_err, got.err);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== got.rdata || o_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b rdata=%08h req_ready=%b required 1/%08h/0",
                         nm, i, o_rsp_valid, o_rsp_rdata, o_req_ready, got.rdata);
            end
        end
        rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        checks++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: valid=%b req_ready=%b required 0/1", nm, o_rsp_valid, o_req_ready);
        end
        $display("txn %s we=%0d addr=%08h wdata=%08h rdata=%08h err=%b lat=%0d",
                 nm, w, a, d, o_rsp_rdata, o_rsp_err, n);
    endtask

    task automatic test_reset();
        v = 1'b0; rr = 1'b0; we = 2'b00; addr = '0; wdata = '0; sel = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: ready=%b valid=%b rdata=%08h err=%b required 1/0/00000000/0",
                         s, o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err);
            end
        end
        sel = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    task automatic test_basic();
        sel = 1'b0;
        do_access(2'b11, 32'h10, 32'hDEADBEEF, 0, "basic_wr");
        do_access(2'b00, 32'h10, 32'h0, 0, "basic_rd");
        do_access(2'b00, 32'h13, 32'h0, 0, "basic_rd_low_ignored");
    endtask

    task automatic test_lanes();
        sel = 1'b0;
        do_access(2'b11, 32'h10, 32'h00000000, 0, "lanes_clear");
        do_access(2'b01, 32'h13, 32'h777777AB, 0, "lanes_byte3");
        do_access(2'b10, 32'h10, 32'h55551234, 0, "lanes_half0");
        do_access(2'b00, 32'h10, 32'h0, 0, "lanes_rd1");
        checks++;
        if (last_rd[0] !== 32'hAB001234) begin
            errors++;
            $display("FAIL lanes_model: got %08h required AB001234", last_rd[0]);
        end
        do_access(2'b01, 32'h11, 32'h0000005A, 0, "lanes_byte1");
        do_access(2'b10, 32'h12, 32'h0000BEEF, 0, "lanes_half1");
        do_access(2'b00, 32'h10, 32'h0, 0, "lanes_rd2");
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        do_access(2'b00, 32'h10, 32'h0, 5, "backpressure_rd");
        do_access(2'b11, 32'h14, 32'h0BADF00D, 5, "backpressure_wr");
    endtask

    task automatic test_misaligned();
        sel = 1'b0;
        do_access(2'b11, 32'h00, 32'hCAFEF00D, 0, "mis_init");
        do_access(2'b11, 32'h02, 32'h01020304, 0, "mis_word");
        do_access(2'b10, 32'h01, 32'h0000AAAA, 0, "mis_half");
        do_access(2'b00, 32'h00, 32'h0, 0, "mis_rd");
        do_access(2'b00, 32'h1000, 32'h0, 0, "range_rd");
        do_access(2'b11, 32'h1004, 32'h44444444, 0, "range_wr");
        do_access(2'b00, 32'h04, 32'h0, 0, "range_rd_word1");
    endtask

    task automatic test_reset_in_access();
        sel = 1'b0;
        do_access(2'b11, 32'h20, 32'h11112222, 0, "rst_pre");
        @(negedge clk);
        v = 1'b1; we = 2'b11; addr = 32'h20; wdata = 32'h99999999;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_accept: req_ready=%b required 1", o_req_ready);
        end
        @(negedge clk);
        v = 1'b0;
        // Counter reaches 0 here, so reset lands on the would-be write edge.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_rd[0] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_drop%0d: valid=%b req_ready=%b required 0/1", i, o_rsp_valid, o_req_ready);
            end
        end
        do_access(2'b00, 32'h20, 32'h0, 0, "rst_post_rd");
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        for (int i = 0; i < 4; i++)
            do_access(2'b11, 32'(i * 4), 32'hA0A0_0000 + 32'(i), 0, $sformatf("b2b_wr%0d", i));
        do_access(2'b00, 32'h0C, 32'h0, 0, "b2b_rd3");
        do_access(2'b00, 32'h10, 32'h0, 0, "b2b_wrap_rd");
        do_access(2'b01, 32'h05, 32'h000000EE, 0, "b2b_byte");
        do_access(2'b00, 32'h04, 32'h0, 0, "b2b_rd1");
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_backpressure();
        test_misaligned();
        test_reset_in_access();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
